accumulator_drain_controller: RTL and testbench

//  Sequences the double-buffered accumulator banks between tiles. On a tile-done request it pulses

---
 rtl/accumulator_drain_controller_if.sv | 50 +++++
 rtl/accumulator_drain_controller.sv | 146 ++++++++++++++
 tb/tb_accumulator_drain_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accumulator_drain_controller_if.sv
// rtl/accumulator_drain_controller_if.sv - tile handshake, bank read port and drain stream bundle
interface accumulator_drain_controller_if #(
    parameter int BUFFER_WIDTH           = 8,
    parameter int TILE_SIZE              = 256,
    parameter int SMALLEST_ELEMENT_WIDTH = 4
);
    localparam int BANK_W  = $clog2(TILE_SIZE);
    localparam int ENTRY_W = $clog2(BUFFER_WIDTH);
    localparam int DATA_W  = SMALLEST_ELEMENT_WIDTH * 4;

    logic                tile_done;
    logic                tile_ack;
    logic                transfer;
    logic [BANK_W-1:0]   back_buffer_bank_read;
    logic [ENTRY_W-1:0]  back_buffer_bank_entry;
    logic [DATA_W-1:0]   back_buffer_data_read;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;
    logic                busy;

    modport master (
        input  tile_done,
        output tile_ack,
        output transfer,
        output back_buffer_bank_read,
        output back_buffer_bank_entry,
        input  back_buffer_data_read,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last,
        output busy
    );

    modport slave (
        output tile_done,
        input  tile_ack,
        input  transfer,
        input  back_buffer_bank_read,
        input  back_buffer_bank_entry,
        output back_buffer_data_read,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last,
        input  busy
    );
endinterface

// File: rtl/accumulator_drain_controller.sv
// rtl/accumulator_drain_controller.sv - swaps accumulator buffers and drains the back buffer as a stream
module accumulator_drain_controller #(
    parameter int BUFFER_WIDTH           = 8,
    parameter int TILE_SIZE              = 256,
    parameter int SMALLEST_ELEMENT_WIDTH = 4,
    parameter int BANK_COUNT             = 256
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    accumulator_drain_controller_if.master bus
);
    localparam int BANK_W  = $clog2(TILE_SIZE);
    localparam int ENTRY_W = $clog2(BUFFER_WIDTH);
    localparam int DATA_W  = SMALLEST_ELEMENT_WIDTH * 4;

    localparam logic [BANK_W-1:0]  LAST_BANK  = BANK_W'(BANK_COUNT - 1);
    localparam logic [ENTRY_W-1:0] LAST_ENTRY = ENTRY_W'(BUFFER_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWAP  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [BANK_W-1:0]   r_bank;
    logic [ENTRY_W-1:0]  r_entry;
    logic                r_addr_done;

    logic [DATA_W-1:0]   r_fifo_data [2];
    logic [1:0]          r_fifo_last;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_transfer;
    logic                w_fifo_has_room;
    logic                w_issue;
    logic                w_pop;
    logic                w_addr_last;
    logic                w_head_last;
    logic                w_out_valid;

    assign w_addr_last  = (r_bank == LAST_BANK) && (r_entry == LAST_ENTRY);
    assign w_out_valid  = (r_count != 2'd0);
    assign w_head_last  = r_fifo_last[r_rd_ptr];
    assign w_pop        = w_out_valid && bus.out_ready;

    // A full FIFO may still take a read when its head leaves in the same cycle.
    assign w_fifo_has_room = (r_count < 2'd2) || ((r_count == 2'd2) && bus.out_ready);
    assign w_issue         = (r_state == ST_DRAIN) && !r_addr_done && w_fifo_has_room;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_transfer   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.tile_done) begin
                    w_next_state = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_transfer   = 1'b1;
                w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Walk entries inside banks; stop on the final address instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bank      <= '0;
            r_entry     <= '0;
            r_addr_done <= 1'b0;
        end else if (r_state == ST_SWAP) begin
            r_bank      <= '0;
            r_entry     <= '0;
            r_addr_done <= 1'b0;
        end else if (w_issue) begin
            if (w_addr_last) begin
                r_addr_done <= 1'b1;
            end else if (r_entry == LAST_ENTRY) begin
                r_entry <= '0;
                r_bank  <= r_bank + BANK_W'(1);
            end else begin
                r_entry <= r_entry + ENTRY_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fifo_last <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_issue) begin
                r_fifo_last[r_wr_ptr] <= w_addr_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through the valid-gated output.
    always_ff @(posedge i_clk) begin
        if (w_issue) begin
            r_fifo_data[r_wr_ptr] <= bus.back_buffer_data_read;
        end
    end

    assign bus.transfer               = w_transfer;
    assign bus.tile_ack               = w_transfer;
    assign bus.busy                   = (r_state != ST_IDLE);
    assign bus.back_buffer_bank_read  = (r_state == ST_DRAIN) ? r_bank  : '0;
    assign bus.back_buffer_bank_entry = (r_state == ST_DRAIN) ? r_entry : '0;
    assign bus.out_valid              = w_out_valid;
    assign bus.out_data               = w_out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.out_last               = w_out_valid && w_head_last;
endmodule

// File: tb/tb_accumulator_drain_controller.sv
// tb/tb_accumulator_drain_controller.sv - scoreboard bench for accumulator_drain_controller
module tb_accumulator_drain_controller;
    localparam int BW  = 2;
    localparam int TS  = 256;
    localparam int SEW = 4;
    localparam int BC  = 4;
    localparam int NW  = BC * BW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    accumulator_drain_controller_if #(
        .BUFFER_WIDTH(BW), .TILE_SIZE(TS), .SMALLEST_ELEMENT_WIDTH(SEW)
    ) bus ();

    accumulator_drain_controller #(
        .BUFFER_WIDTH(BW), .TILE_SIZE(TS), .SMALLEST_ELEMENT_WIDTH(SEW), .BANK_COUNT(BC)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .bus(bus)
    );

    // Bank model: word is {bank, entry}, each a byte.
    assign bus.back_buffer_data_read = {bus.back_buffer_bank_read, 7'd0, bus.back_buffer_bank_entry};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [16:0] sb[$];
    logic [16:0] exp_w;
    int          n_xfer  = 0;
    int          n_last  = 0;
    int          n_words = 0;
    logic        prev_busy = 1'b0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic request_tile();
        bus.tile_done = 1'b1;
        for (int b = 0; b < BC; b++)
            for (int e = 0; e < BW; e++)
                sb.push_back({(b == BC - 1) && (e == BW - 1), 8'(b), 8'(e)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (bus.busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout_busy", bus.busy, 0);
        step();
    endtask

    // Monitor: pops the scoreboard on each accepted word and watches protocol rules.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.transfer) begin
                check("ack_with_transfer", bus.tile_ack, 1);
                check("transfer_after_idle", prev_busy, 0);
                n_xfer++;
            end
            if (!bus.busy) check("idle_fifo_empty", bus.out_valid, 0);
            if (prev_hold) check("data_stable_under_stall", bus.out_data, prev_data);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
                end else begin
                    exp_w = sb.pop_front();
                    check("out_data", bus.out_data, exp_w[15:0]);
                    check("out_last", bus.out_last, exp_w[16]);
                end
                n_words++;
                if (bus.out_last) n_last++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_busy = bus.busy;
        end else begin
            prev_hold = 1'b0;
            prev_busy = 1'b0;
        end
    end

    task automatic two_tiles(input int req_k);
        int second_k;
        int x0;
        second_k = -1;
        x0 = n_xfer;
        bus.out_ready = 1'b1;
        request_tile();
        for (int k = 0; k <= 25; k++) begin
            if (k == 1 || k == 13) bus.tile_done = 1'b0;
            if (k == req_k) request_tile();
            @(negedge clk);
            if (k == 11) check("gap_idle_busy", bus.busy, 0);
            if (bus.transfer && k > 1 && second_k < 0) second_k = k;
            step();
        end
        check("second_transfer_cycle", second_k, 12);
        wait_idle();
        check("two_tiles_transfers", n_xfer - x0, 2);
        check("two_tiles_sb_empty", sb.size(), 0);
    endtask

    initial begin
        int x0, l0, w0, k;
        reset         = 1'b1;
        bus.tile_done = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_transfer", bus.transfer, 0);
        check("rst_ack", bus.tile_ack, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_bank", bus.back_buffer_bank_read, 0);
        check("rst_entry", bus.back_buffer_bank_entry, 0);
        check("rst_data", bus.out_data, 0);
        step();
        reset = 1'b0;
        step();

        // 1: basic timing with out_ready held high
        bus.out_ready = 1'b1;
        request_tile();
        for (int kk = 0; kk <= 12; kk++) begin
            if (kk == 1) bus.tile_done = 1'b0;
            @(negedge clk);
            check("t1_transfer", bus.transfer, kk == 1);
            check("t1_valid", bus.out_valid, (kk >= 3) && (kk <= 10));
            check("t1_last", bus.out_last, kk == 10);
            check("t1_busy", bus.busy, (kk >= 1) && (kk <= 10));
            step();
        end

        // 2: backpressure for cycles 3..6
        w0 = n_words;
        request_tile();
        for (int kk = 0; kk <= 14; kk++) begin
            if (kk == 1) bus.tile_done = 1'b0;
            bus.out_ready = !((kk >= 3) && (kk <= 6));
            @(negedge clk);
            if (kk >= 3 && kk <= 6) begin
                check("t2_hold_valid", bus.out_valid, 1);
                check("t2_hold_data", bus.out_data, 16'h0000);
            end
            if (kk >= 4 && kk <= 6) begin
                check("t2_hold_bank", bus.back_buffer_bank_read, 1);
                check("t2_hold_entry", bus.back_buffer_bank_entry, 0);
            end
            step();
        end
        bus.out_ready = 1'b1;
        wait_idle();
        check("t2_word_count", n_words - w0, NW);
        check("t2_sb_empty", sb.size(), 0);

        // 3: random out_ready over 20 tiles
        x0 = n_xfer;
        l0 = n_last;
        w0 = n_words;
        for (int t = 0; t < 20; t++) begin
            request_tile();
            k = 0;
            while (k < 400) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (k == 1) bus.tile_done = 1'b0;
                @(negedge clk);
                if (k >= 1 && !bus.busy) break;
                k++;
                step();
            end
            check("t3_tile_timeout", k < 400, 1);
            step();
        end
        bus.out_ready = 1'b1;
        check("t3_transfers", n_xfer - x0, 20);
        check("t3_last_count", n_last - l0, 20);
        check("t3_word_count", n_words - w0, 20 * NW);
        check("t3_sb_empty", sb.size(), 0);

        // 4: request held from cycle 5 of a drain
        two_tiles(5);

        // 5: reset mid-drain
        request_tile();
        for (int kk = 0; kk <= 8; kk++) begin
            if (kk == 1) bus.tile_done = 1'b0;
            if (kk == 6) reset = 1'b1;
            if (kk == 7) begin
                reset = 1'b0;
                sb.delete();
            end
            @(negedge clk);
            if (kk == 7 || kk == 8) begin
                check("t5_transfer", bus.transfer, 0);
                check("t5_valid", bus.out_valid, 0);
                check("t5_busy", bus.busy, 0);
                check("t5_bank", bus.back_buffer_bank_read, 0);
                check("t5_entry", bus.back_buffer_bank_entry, 0);
                check("t5_last", bus.out_last, 0);
                check("t5_data", bus.out_data, 0);
            end
            step();
        end
        request_tile();
        for (int kk = 0; kk <= 2; kk++) begin
            if (kk == 1) bus.tile_done = 1'b0;
            @(negedge clk);
            if (kk == 2) begin
                check("t5_restart_bank", bus.back_buffer_bank_read, 0);
                check("t5_restart_entry", bus.back_buffer_bank_entry, 0);
            end
            step();
        end
        wait_idle();
        check("t5_sb_empty", sb.size(), 0);

        // 6: new request in the same cycle as the last-word accept
        two_tiles(10);

        step();
        check("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
